// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: sequencer states and the owner-index width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Width of an index able to name every requester (at least one bit).
    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches upward from ptr+1 with wrap and
// returns the first requesting index.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int OW      = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [OW-1:0]      i_ptr,
    output logic [OW-1:0]      o_grant,
    output logic               o_any_grant
);

    always_comb begin
        o_grant     = '0;
        o_any_grant = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!o_any_grant && i_req[j] && (j == (int'(i_ptr) + k) % NUM_REQ)) begin
                    o_grant     = OW'(j);
                    o_any_grant = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port memory between NUM_REQ
// requesters; one 4-cycle transaction (IDLE, ISSUE, WAIT, RESP) at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          mem_wr,
    output logic                          mem_rd,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    input  logic                          mem_response,
    output state_t                        o_state
);

    localparam int OW = owner_width(NUM_REQ);

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [OW-1:0]        r_ptr;
    logic [NUM_REQ-1:0]   r_owner_oh;
    cmd_t                 r_cmd;
    logic [OW-1:0]        w_grant;
    logic                 w_any;
    logic [NUM_REQ-1:0]   w_grant_oh;
    cmd_t                 w_pick;
    logic [NUM_REQ-1:0]   r_req_ready;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                 r_rsp_err;
    logic                 r_mem_wr;
    logic                 r_mem_rd;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [OW-1:0]        r_owner;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .OW      (OW)
    ) u_rr (
        .i_req       (req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_any_grant (w_any)
    );

    always_comb begin
        w_pick     = '0;
        w_grant_oh = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (OW'(j) == w_grant) begin
                w_pick.write  = req_write[j];
                w_pick.addr   = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                w_pick.wdata  = req_wdata[j*DATA_WIDTH +: DATA_WIDTH];
                w_grant_oh[j] = w_any;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next_state = ISSUE;
            ISSUE:   w_next_state = WAIT;
            WAIT:    w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Outputs are registered, so strobes and pulses are loaded one state ahead.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= OW'(NUM_REQ - 1);
            r_owner     <= '0;
            r_owner_oh  <= '0;
            r_cmd       <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_mem_wr    <= 1'b0;
            r_mem_rd    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner     <= w_grant;
                        r_owner_oh  <= w_grant_oh;
                        r_cmd       <= w_pick;
                        r_req_ready <= w_grant_oh;
                        r_mem_wr    <= w_pick.write;
                        r_mem_rd    <= !w_pick.write;
                        r_mem_addr  <= w_pick.addr;
                        r_mem_wdata <= w_pick.wdata;
                    end
                end
                ISSUE: r_ptr <= r_owner;
                WAIT: begin
                    r_rsp_valid <= r_owner_oh;
                    r_rsp_rdata <= r_cmd.write ? '0 : mem_rdata;
                    r_rsp_err   <= r_cmd.write & !mem_response;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign mem_wr    = r_mem_wr;
    assign mem_rd    = r_mem_rd;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign o_state   = r_state;

endmodule
